// File: rtl/flop_adder.sv
// flop_adder: pipelined adder for a sign | biased exponent | hidden-one fraction float format.
// Operands are captured, aligned, then added, normalized and rounded to nearest-even.
module flop_adder #(
    parameter int EXP_W  = 4,
    parameter int FRAC_W = 8,
    parameter int BIAS   = 7
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    input  logic [EXP_W+FRAC_W:0]       one,
    input  logic [EXP_W+FRAC_W:0]       other,
    output logic                        out_valid,
    output logic [EXP_W+FRAC_W:0]       result,
    output logic                        overflow
);
    localparam int W       = 1 + EXP_W + FRAC_W;
    localparam int SIG_W   = FRAC_W + 1;
    localparam int EXT_W   = SIG_W + 3;
    localparam int MAG_W   = EXP_W + FRAC_W;
    localparam int EXP_MAX = (1 << EXP_W) - 1;

    function automatic int lead_zeros(input logic [EXT_W-1:0] v);
        int n;
        n = EXT_W;
        for (int i = 0; i < EXT_W; i++) begin
            if (v[i]) begin
                n = EXT_W - 1 - i;
            end else begin
                n = n;
            end
        end
        return n;
    endfunction

    logic             in_valid_d, in_valid_q;
    logic [W-1:0]     one_d, one_q, other_d, other_q;
    logic             s1_valid_d, s1_valid_q, s1_sign_d, s1_sign_q, s1_sub_d, s1_sub_q;
    logic [EXP_W-1:0] s1_exp_d, s1_exp_q;
    logic [EXT_W-1:0] s1_big_d, s1_big_q, s1_small_d, s1_small_q;
    logic             out_valid_d, out_valid_q, overflow_d, overflow_q;
    logic [W-1:0]     result_d, result_q;

    logic [MAG_W-1:0] mag_a_s, mag_b_s, mag_l_s, mag_m_s;
    logic [EXP_W-1:0] diff_s;
    logic [SIG_W-1:0] sig_l_s, sig_m_s;
    logic [EXT_W-1:0] ext_m_s, lost_mask_s;

    logic [EXT_W:0]    sum_s;
    logic [EXT_W-1:0]  norm_s;
    logic [SIG_W:0]    rnd_s;
    logic [FRAC_W-1:0] frac_s;
    logic              round_up_s;
    int                exp_s;

    // Input capture stage.
    always_comb begin
        in_valid_d = in_valid;
        one_d      = one;
        other_d    = other;
    end

    // Stage 1: flush zeros, order by magnitude, align the smaller significand with G/R/S.
    always_comb begin
        mag_a_s = (one_q[W-2 -: EXP_W] == {EXP_W{1'b0}}) ? {MAG_W{1'b0}} : one_q[MAG_W-1:0];
        mag_b_s = (other_q[W-2 -: EXP_W] == {EXP_W{1'b0}}) ? {MAG_W{1'b0}} : other_q[MAG_W-1:0];
        if (mag_b_s > mag_a_s) begin
            mag_l_s   = mag_b_s;
            mag_m_s   = mag_a_s;
            s1_sign_d = other_q[W-1];
        end else begin
            mag_l_s   = mag_a_s;
            mag_m_s   = mag_b_s;
            s1_sign_d = one_q[W-1];
        end
        sig_l_s = (mag_l_s[MAG_W-1 -: EXP_W] == {EXP_W{1'b0}}) ? {SIG_W{1'b0}} : {1'b1, mag_l_s[FRAC_W-1:0]};
        sig_m_s = (mag_m_s[MAG_W-1 -: EXP_W] == {EXP_W{1'b0}}) ? {SIG_W{1'b0}} : {1'b1, mag_m_s[FRAC_W-1:0]};
        diff_s  = mag_l_s[MAG_W-1 -: EXP_W] - mag_m_s[MAG_W-1 -: EXP_W];
        ext_m_s = {sig_m_s, 3'b000};
        lost_mask_s = ~({EXT_W{1'b1}} << diff_s);
        if (int'(diff_s) >= EXT_W - 1) begin
            s1_small_d = {{(EXT_W-1){1'b0}}, |sig_m_s};
        end else begin
            s1_small_d = (ext_m_s >> diff_s) | {{(EXT_W-1){1'b0}}, |(ext_m_s & lost_mask_s)};
        end
        s1_big_d   = {sig_l_s, 3'b000};
        s1_exp_d   = mag_l_s[MAG_W-1 -: EXP_W];
        s1_sub_d   = one_q[W-1] ^ other_q[W-1];
        s1_valid_d = in_valid_q;
    end

    // Stage 2: add/subtract, normalize, round to nearest-even, range-check and pack.
    always_comb begin
        if (s1_sub_q) begin
            sum_s = {1'b0, s1_big_q} - {1'b0, s1_small_q};
        end else begin
            sum_s = {1'b0, s1_big_q} + {1'b0, s1_small_q};
        end
        exp_s = int'(s1_exp_q) - BIAS;
        if (sum_s[EXT_W]) begin
            norm_s = {sum_s[EXT_W:2], sum_s[1] | sum_s[0]};
            exp_s  = exp_s + 32'sd1;
        end else begin
            norm_s = sum_s[EXT_W-1:0] << lead_zeros(sum_s[EXT_W-1:0]);
            exp_s  = exp_s - lead_zeros(sum_s[EXT_W-1:0]);
        end
        round_up_s = norm_s[2] & (norm_s[3] | norm_s[1] | norm_s[0]);
        rnd_s      = {1'b0, norm_s[EXT_W-1:3]} + {{SIG_W{1'b0}}, round_up_s};
        // A rounding carry leaves 10.00..0, i.e. a zero fraction one exponent higher.
        if (rnd_s[SIG_W]) begin
            frac_s = rnd_s[SIG_W-1:1];
            exp_s  = exp_s + 32'sd1;
        end else begin
            frac_s = rnd_s[FRAC_W-1:0];
        end
        out_valid_d = s1_valid_q;
        result_d    = result_q;
        overflow_d  = overflow_q;
        if (s1_valid_q) begin
            if ((sum_s == {(EXT_W+1){1'b0}}) || (exp_s < 1 - BIAS)) begin
                result_d   = {W{1'b0}};
                overflow_d = 1'b0;
            end else if (exp_s > EXP_MAX - BIAS) begin
                result_d   = {s1_sign_q, {MAG_W{1'b1}}};
                overflow_d = 1'b1;
            end else begin
                result_d   = {s1_sign_q, EXP_W'(exp_s + BIAS), frac_s};
                overflow_d = 1'b0;
            end
        end else begin
            result_d   = result_q;
            overflow_d = overflow_q;
        end
    end

    // Pipeline registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_valid_q  <= 1'b0;
            one_q       <= {W{1'b0}};
            other_q     <= {W{1'b0}};
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_sub_q    <= 1'b0;
            s1_exp_q    <= {EXP_W{1'b0}};
            s1_big_q    <= {EXT_W{1'b0}};
            s1_small_q  <= {EXT_W{1'b0}};
            out_valid_q <= 1'b0;
            result_q    <= {W{1'b0}};
            overflow_q  <= 1'b0;
        end else begin
            in_valid_q  <= in_valid_d;
            one_q       <= one_d;
            other_q     <= other_d;
            s1_valid_q  <= s1_valid_d;
            s1_sign_q   <= s1_sign_d;
            s1_sub_q    <= s1_sub_d;
            s1_exp_q    <= s1_exp_d;
            s1_big_q    <= s1_big_d;
            s1_small_q  <= s1_small_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            overflow_q  <= overflow_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign overflow  = overflow_q;
endmodule

// File: tb/tb_flop_adder.sv
// tb_flop_adder: randomized scoreboard bench; expected sums come from exact integer arithmetic.
module tb_flop_adder;
    logic        clk = 1'b0;
    logic        reset, in_valid, out_valid, overflow;
    logic [12:0] one, other, result;

    always #5 clk = ~clk;

    flop_adder dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .one(one), .other(other),
        .out_valid(out_valid), .result(result), .overflow(overflow)
    );

    typedef struct {
        logic [12:0] res;
        logic        ovf;
        int          edge_n;
    } item_t;

    item_t       sb_q[$];
    int          cyc = 0;
    int          rst_edge = -100;
    int          errors = 0;
    int          checks = 0;
    logic [12:0] last_res = 13'h0000;

    // Value of a word in units of 2^-14 (the weight of the lowest fraction bit at exponent 1).
    function automatic int to_units(input logic [12:0] x);
        int e;
        int m;
        e = int'(x[11:8]);
        if (e == 0) return 0;
        m = (256 + int'(x[7:0])) << (e - 1);
        return x[12] ? -m : m;
    endfunction

    // Exact sum, then round-to-nearest-even into the format; returns {overflow, word}.
    function automatic logic [13:0] ref_add(input logic [12:0] a, input logic [12:0] b);
        int s, mag, p, sh, q, rem, half, e;
        logic neg;
        s = to_units(a) + to_units(b);
        if (s == 0) return 14'h0000;
        neg = (s < 0);
        mag = neg ? -s : s;
        p = 0;
        for (int i = 0; i < 31; i++) if (mag >= (1 << i)) p = i;
        e = p - 7;
        if (e < 1) return 14'h0000;
        sh   = p - 8;
        q    = mag >> sh;
        rem  = mag - (q << sh);
        half = (sh > 0) ? (1 << (sh - 1)) : 0;
        if (sh > 0 && (rem > half || (rem == half && (q % 2) == 1))) q = q + 1;
        if (q == 512) begin
            q = 256;
            e = e + 1;
        end
        if (e > 15) return {1'b1, neg, 12'hFFF};
        return {1'b0, neg, 4'(e), 8'(q - 256)};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic issue(input logic [12:0] a, input logic [12:0] b);
        item_t it;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        one      = a;
        other    = b;
        it.edge_n = cyc + 1;
        {it.ovf, it.res} = ref_add(a, b);
        sb_q.push_back(it);
    endtask

    task automatic bubble();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        one      = 13'($urandom);
        other    = 13'($urandom);
    endtask

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (reset) rst_edge = cyc;
    end

    // Monitor: pops the scoreboard whenever the DUT presents a result.
    always @(negedge clk) begin
        item_t it;
        while (sb_q.size() > 0 && sb_q[0].edge_n <= rst_edge) sb_q.delete(0);
        if (rst_edge == cyc) begin
            check("reset_state", {17'h0, out_valid, overflow, result}, 32'h0);
            last_res = 13'h0000;
        end else if (rst_edge >= 0) begin
            if (out_valid) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_out_valid", 32'd1, 32'd0);
                end else begin
                    it = sb_q.pop_front();
                    check("latency", cyc, it.edge_n + 2);
                    check("result", {19'h0, result}, {19'h0, it.res});
                    check("overflow", {31'h0, overflow}, {31'h0, it.ovf});
                    last_res = it.res;
                end
            end else begin
                check("result_hold", {19'h0, result}, {19'h0, last_res});
                if (sb_q.size() > 0 && sb_q[0].edge_n + 2 <= cyc) begin
                    check("missing_out_valid", 32'd0, 32'd1);
                    sb_q.delete(0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [12:0] a, b;
        reset = 1'b1;
        in_valid = 1'b0;
        one = 13'h0000;
        other = 13'h0000;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        issue(13'h1A01, 13'h0922);
        issue(13'h0000, 13'h0922);
        issue(13'h0922, 13'h0000);
        bubble();
        issue(13'h0922, 13'h1922);
        issue(13'h0FFF, 13'h0FFF);
        issue(13'h0B00, 13'h0200);
        // 3/64 is 0.75 ulp above 16, so this one rounds up by a single ulp.
        issue(13'h0B00, 13'h0280);
        issue(13'h0105, 13'h1100);
        issue(13'h0050, 13'h0922);
        bubble();
        bubble();

        issue(13'h0A10, 13'h0333);
        issue(13'h1777, 13'h0456);
        issue(13'h0C01, 13'h1C00);
        @(posedge clk);
        #1 reset = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                bubble();
            end else begin
                a = 13'($urandom);
                b = 13'($urandom);
                case ($urandom_range(0, 3))
                    0: b[11:8] = a[11:8] ^ 4'($urandom_range(0, 1));
                    1: b = a ^ 13'h1000;
                    default: b = b;
                endcase
                issue(a, b);
            end
        end
        repeat (6) bubble();
        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
